// File: rtl/rca_pipe_addsub_if.sv
// Operand/result handshake bundle for rca_pipe_addsub.
// The master side is the producer/consumer pair; the slave side is the adder.
interface rca_pipe_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, carry, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, carry, overflow
   );
endinterface

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry add/subtract: one CHUNK-bit ripple slice per register stage,
// valid/ready flow control with a single global advance and fixed STAGES-cycle latency.
module rca_pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic               clk,
   input logic               rst_n,
   rca_pipe_addsub_if.slave  io
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   logic             advance;
   logic [WIDTH-1:0] beff;
   logic             cin_eff;
   logic             ov_q;

   assign beff    = io.b ^ {WIDTH{io.sub}};
   assign cin_eff = io.sub | io.cin;

   // Each stage keeps only the operand bits still to be added and the result bits
   // already produced, so register widths shrink/grow by CHUNK per stage.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;
      localparam int HI = LO + CHUNK;

      logic [WIDTH-1:LO] ai;
      logic [WIDTH-1:LO] bi;
      logic              ci;
      logic              vi;
      logic [CHUNK:0]    part;
      logic [HI-1:0]     r_nxt;
      logic              v_q;
      logic              c_q;
      logic [HI-1:0]     r_q;

      if (k == 0) begin : g_src
         assign vi    = io.in_valid;
         assign ai    = io.a;
         assign bi    = beff;
         assign ci    = cin_eff;
         assign r_nxt = part[CHUNK-1:0];
      end else begin : g_src
         assign vi    = g_stage[k-1].v_q;
         assign ai    = g_stage[k-1].g_fwd.ua_q;
         assign bi    = g_stage[k-1].g_fwd.ub_q;
         assign ci    = g_stage[k-1].c_q;
         assign r_nxt = {part[CHUNK-1:0], g_stage[k-1].r_q};
      end

      assign part = {1'b0, ai[HI-1:LO]} + {1'b0, bi[HI-1:LO]} + (CHUNK+1)'(ci);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            r_q <= '0;
         end else if (advance) begin
            v_q <= vi;
            c_q <= part[CHUNK];
            r_q <= r_nxt;
         end
      end

      if (k < LAST) begin : g_fwd
         logic [WIDTH-1:HI] ua_q;
         logic [WIDTH-1:HI] ub_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ua_q <= '0;
               ub_q <= '0;
            end else if (advance) begin
               ua_q <= ai[WIDTH-1:HI];
               ub_q <= bi[WIDTH-1:HI];
            end
         end
      end
   end

   assign advance = !g_stage[LAST].v_q || io.out_ready;

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q <= 1'b0;
      end else if (advance) begin
         ov_q <= g_stage[LAST].part[CHUNK] ^ g_stage[LAST].part[CHUNK-1]
               ^ g_stage[LAST].ai[WIDTH-1] ^ g_stage[LAST].bi[WIDTH-1];
      end
   end

   assign io.in_ready  = advance;
   assign io.out_valid = g_stage[LAST].v_q;
   assign io.sum       = g_stage[LAST].r_q;
   assign io.carry     = g_stage[LAST].c_q;
   assign io.overflow  = ov_q;
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Directed bench for rca_pipe_addsub: 4-slice pipe (CHUNK=4) plus a single-slice
// instance (CHUNK=16) sharing clock and reset.
module tb_rca_pipe_addsub;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   rca_pipe_addsub_if #(.WIDTH(16)) io ();
   rca_pipe_addsub_if #(.WIDTH(16)) io16 ();

   rca_pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   rca_pipe_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s);
      io.in_valid = v;
      io.a        = a;
      io.b        = b;
      io.cin      = ci;
      io.sub      = s;
   endtask

   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo);
      drive(1'b1, a, b, ci, s);
      step();
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      step();
      step();
      check({tag, "_early"}, io.out_valid, 0);
      step();
      check({tag, "_valid"}, io.out_valid, 1);
      check({tag, "_sum"},   io.sum, es);
      check({tag, "_carry"}, io.carry, ec);
      check({tag, "_ovf"},   io.overflow, eo);
      step();
   endtask

   initial begin
      logic [15:0] held;

      rst_n = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      io.out_ready   = 1'b1;
      io16.in_valid  = 1'b0;
      io16.a         = 16'h0000;
      io16.b         = 16'h0000;
      io16.cin       = 1'b0;
      io16.sub       = 1'b0;
      io16.out_ready = 1'b1;

      #1 rst_n = 1'b0;
      #2;
      check("rst_valid", io.out_valid, 0);
      check("rst_sum",   io.sum, 0);
      check("rst_carry", io.carry, 0);
      check("rst_ovf",   io.overflow, 0);
      check("rst_ready", io.in_ready, 1);
      check("rst16_valid", io16.out_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_one("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("cinslice", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
      run_one("subneg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_one("subcin",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("subzero",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Streaming: a=i, b=2i, results 3i from the fourth edge onwards.
      for (int c = 0; c < 14; c++) begin
         if (c < 8) drive(1'b1, 16'(c), 16'(2 * c), 1'b0, 1'b0);
         else       drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
         step();
         if (c >= 3 && c < 11) begin
            check("stream_valid", io.out_valid, 1);
            check("stream_sum",   io.sum, 32'(3 * (c - 3)));
         end else begin
            check("stream_idle",  io.out_valid, 0);
         end
      end

      // Backpressure: fill with ops 0..3, stall 3 edges with op 4 offered.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'(16'h0A00 + 16'h0101 * k), 16'h0033, 1'b0, 1'b0);
         step();
      end
      check("bp_full_valid", io.out_valid, 1);
      check("bp_full_sum",   io.sum, 16'h0A33);
      held = 16'h0A33;
      drive(1'b1, 16'(16'h0A00 + 16'h0101 * 4), 16'h0033, 1'b0, 1'b0);
      io.out_ready = 1'b0;
      #1;
      check("bp_ready_low", io.in_ready, 0);
      for (int h = 0; h < 3; h++) begin
         step();
         check("bp_hold_ready", io.in_ready, 0);
         check("bp_hold_valid", io.out_valid, 1);
         check("bp_hold_sum",   io.sum, held);
      end
      io.out_ready = 1'b1;
      #1;
      check("bp_release_ready", io.in_ready, 1);
      for (int k = 1; k <= 4; k++) begin
         step();
         drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
         check("bp_drain_valid", io.out_valid, 1);
         check("bp_drain_sum",   io.sum, 32'(16'(16'h0A00 + 16'h0101 * k + 16'h0033)));
      end
      step();
      check("bp_empty", io.out_valid, 0);

      // Reset mid-stream with the pipe full.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'h8001, 16'h8001, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      check("pre_rst_sum",   io.sum, 16'h0002);
      check("pre_rst_carry", io.carry, 1);
      check("pre_rst_ovf",   io.overflow, 1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", io.out_valid, 0);
      check("mid_rst_sum",   io.sum, 0);
      check("mid_rst_carry", io.carry, 0);
      check("mid_rst_ovf",   io.overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         check("post_rst_idle", io.out_valid, 0);
      end

      // Single-slice instance: one-cycle latency.
      io16.in_valid = 1'b1;
      io16.a        = 16'hFFFF;
      io16.b        = 16'h0001;
      step();
      io16.in_valid = 1'b0;
      check("c16_valid", io16.out_valid, 1);
      check("c16_sum",   io16.sum, 16'h0000);
      check("c16_carry", io16.carry, 1);
      check("c16_ovf",   io16.overflow, 0);
      step();
      check("c16_idle",  io16.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
